// File: rtl/axi_ddr_throttle_if.sv
// Softreg bundle types and the AXI4 bus interface used by axi_ddr_throttle.
// The package holds the softreg request/response structs; the interface carries one AXI4 port.
package axi_ddr_throttle_pkg;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

endpackage

interface axi_bus_t #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_ddr_throttle.sv
// axi_ddr_throttle: per-DDR-channel outstanding-burst limiter and traffic counters.
// Define AXI_THROTTLE_LAT_EN to add the 48-bit read latency accumulator at +0x30.
module axi_ddr_throttle
    import axi_ddr_throttle_pkg::*;
#(
    parameter logic [31:0] SR_ADDR = 32'h20,
    parameter int unsigned MAX_OUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  SoftRegReq  sr_req,
    output SoftRegResp sr_resp,
    axi_bus_t.slave    axi_s,
    axi_bus_t.master   axi_m
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] LIM_MAX = OW'(MAX_OUT);

    logic [OW-1:0]    rd_out_q, rd_out_d;
    logic [OW-1:0]    wr_out_q, wr_out_d;
    logic [OW-1:0]    rd_lim_q, rd_lim_d;
    logic [OW-1:0]    wr_lim_q, wr_lim_d;
    logic [CNT_W-1:0] rd_bursts_q, rd_bursts_d;
    logic [CNT_W-1:0] wr_bursts_q, wr_bursts_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [1:0]       err_q, err_d;
    logic             resp_valid_q, resp_valid_d;
    logic [63:0]      resp_data_q, resp_data_d;

    logic             rd_ok, wr_ok;
    logic             ar_hs, aw_hs, r_done, b_done, stall_cyc;
    logic [31:0]      off;
    logic [2:0]       idx;
    logic             in_rng, rd_en, wr_en;
    logic [6:0]       wr_sel;
    logic [OW-1:0]    lim_wdata;
    logic [63:0]      rdata, lat_rd;
    logic [2*OW+1:0]  status;

    // Issue gating uses registered state only, so ready never depends on valid.
    assign rd_ok = (rd_out_q < rd_lim_q);
    assign wr_ok = (wr_out_q < wr_lim_q);

    assign axi_m.arvalid = axi_s.arvalid & rd_ok;
    assign axi_s.arready = axi_m.arready & rd_ok;
    assign axi_m.awvalid = axi_s.awvalid & wr_ok;
    assign axi_s.awready = axi_m.awready & wr_ok;

    assign axi_m.arid    = axi_s.arid;
    assign axi_m.araddr  = axi_s.araddr;
    assign axi_m.arlen   = axi_s.arlen;
    assign axi_m.arsize  = axi_s.arsize;
    assign axi_m.arburst = axi_s.arburst;
    assign axi_m.awid    = axi_s.awid;
    assign axi_m.awaddr  = axi_s.awaddr;
    assign axi_m.awlen   = axi_s.awlen;
    assign axi_m.awsize  = axi_s.awsize;
    assign axi_m.awburst = axi_s.awburst;
    assign axi_m.wdata   = axi_s.wdata;
    assign axi_m.wstrb   = axi_s.wstrb;
    assign axi_m.wlast   = axi_s.wlast;
    assign axi_m.wvalid  = axi_s.wvalid;
    assign axi_s.wready  = axi_m.wready;
    assign axi_s.bid     = axi_m.bid;
    assign axi_s.bresp   = axi_m.bresp;
    assign axi_s.bvalid  = axi_m.bvalid;
    assign axi_m.bready  = axi_s.bready;
    assign axi_s.rid     = axi_m.rid;
    assign axi_s.rdata   = axi_m.rdata;
    assign axi_s.rresp   = axi_m.rresp;
    assign axi_s.rlast   = axi_m.rlast;
    assign axi_s.rvalid  = axi_m.rvalid;
    assign axi_m.rready  = axi_s.rready;

    assign ar_hs     = axi_s.arvalid & axi_m.arready & rd_ok;
    assign aw_hs     = axi_s.awvalid & axi_m.awready & wr_ok;
    assign r_done    = axi_m.rvalid & axi_s.rready & axi_m.rlast;
    assign b_done    = axi_m.bvalid & axi_s.bready;
    assign stall_cyc = (axi_s.arvalid & ~rd_ok) | (axi_s.awvalid & ~wr_ok);

    // Softreg decode: eight-byte aligned slots 0..6 above SR_ADDR.
    assign off    = sr_req.addr - SR_ADDR;
    assign in_rng = (sr_req.addr >= SR_ADDR) && (off < 32'd56) && (off[2:0] == 3'd0);
    assign idx    = off[5:3];
    assign rd_en  = sr_req.valid & ~sr_req.isWrite & in_rng;
    assign wr_en  = sr_req.valid & sr_req.isWrite & in_rng;

    assign lim_wdata = (sr_req.data > 64'(MAX_OUT)) ? LIM_MAX : sr_req.data[OW-1:0];
    assign status    = {err_q, wr_out_q, rd_out_q};

    // One-hot write strobe per softreg slot.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < 7; k++) begin
            wr_sel[k] = wr_en && (idx == 3'(k));
        end
    end

`ifdef AXI_THROTTLE_LAT_EN
    logic [47:0] lat_q, lat_d;

    // Sum of outstanding reads per cycle; a clear write wins over accumulation.
    always_comb begin
        lat_d = wr_sel[6] ? '0 : lat_q + 48'(rd_out_q);
    end

    // Latency accumulator register.
    always_ff @(posedge clk) begin
        if (rst) lat_q <= '0;
        else     lat_q <= lat_d;
    end

    assign lat_rd = 64'(lat_q);
`else
    assign lat_rd = '0;
`endif

    // Softreg read data mux.
    always_comb begin
        rdata = '0;
        unique case (idx)
            3'd0:    rdata = 64'(rd_lim_q);
            3'd1:    rdata = 64'(wr_lim_q);
            3'd2:    rdata = 64'(rd_bursts_q);
            3'd3:    rdata = 64'(wr_bursts_q);
            3'd4:    rdata = 64'(stall_q);
            3'd5:    rdata = 64'(status);
            3'd6:    rdata = lat_rd;
            default: rdata = '0;
        endcase
    end

    // Next-state: outstanding counts, sticky errors, counters, limits, response.
    always_comb begin
        rd_out_d     = rd_out_q;
        wr_out_d     = wr_out_q;
        err_d        = err_q;
        rd_lim_d     = rd_lim_q;
        wr_lim_d     = wr_lim_q;
        resp_valid_d = rd_en;
        resp_data_d  = resp_data_q;

        if (ar_hs && !r_done) begin
            rd_out_d = rd_out_q + OW'(1);
        end else if (r_done && !ar_hs) begin
            if (rd_out_q == '0) err_d[0] = 1'b1;
            else                rd_out_d = rd_out_q - OW'(1);
        end

        if (aw_hs && !b_done) begin
            wr_out_d = wr_out_q + OW'(1);
        end else if (b_done && !aw_hs) begin
            if (wr_out_q == '0) err_d[1] = 1'b1;
            else                wr_out_d = wr_out_q - OW'(1);
        end

        if (wr_sel[5]) err_d    = '0;
        if (wr_sel[0]) rd_lim_d = lim_wdata;
        if (wr_sel[1]) wr_lim_d = lim_wdata;

        rd_bursts_d = wr_sel[2] ? '0 : rd_bursts_q + CNT_W'(r_done);
        wr_bursts_d = wr_sel[3] ? '0 : wr_bursts_q + CNT_W'(b_done);
        stall_d     = wr_sel[4] ? '0 : stall_q + CNT_W'(stall_cyc);

        if (rd_en) resp_data_d = rdata;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_out_q     <= '0;
            wr_out_q     <= '0;
            rd_lim_q     <= LIM_MAX;
            wr_lim_q     <= LIM_MAX;
            rd_bursts_q  <= '0;
            wr_bursts_q  <= '0;
            stall_q      <= '0;
            err_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            rd_out_q     <= rd_out_d;
            wr_out_q     <= wr_out_d;
            rd_lim_q     <= rd_lim_d;
            wr_lim_q     <= wr_lim_d;
            rd_bursts_q  <= rd_bursts_d;
            wr_bursts_q  <= wr_bursts_d;
            stall_q      <= stall_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign sr_resp.valid = resp_valid_q;
    assign sr_resp.data  = resp_data_q;

endmodule

// File: tb/tb_axi_ddr_throttle.sv
// Directed bench for axi_ddr_throttle: softreg reads go through a response scoreboard,
// AXI gating and pass-through are checked at negedges between driven steps.
module tb_axi_ddr_throttle;
    import axi_ddr_throttle_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    SoftRegReq  sr_req;
    SoftRegResp sr_resp;

    axi_bus_t us ();
    axi_bus_t ds ();

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];
    logic [511:0] wpat;

    axi_ddr_throttle #(
        .SR_ADDR (32'h20),
        .MAX_OUT (64),
        .CNT_W   (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sr_req  (sr_req),
        .sr_resp (sr_resp),
        .axi_s   (us),
        .axi_m   (ds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && sr_resp.valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(sr_resp.valid), 64'd0);
            end else begin
                check("rsp_data", sr_resp.data, sb.pop_front());
            end
        end
    end

    task automatic sr_rd(input logic [31:0] a, input logic [63:0] e);
        sb.push_back(e);
        sr_req.valid = 1'b1;
        sr_req.isWrite = 1'b0;
        sr_req.addr = a;
        @(posedge clk);
        #1 sr_req.valid = 1'b0;
        @(negedge clk);
        check("rsp_latency", 64'(sr_resp.valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic sr_rd_none(input logic [31:0] a);
        sr_req.valid = 1'b1;
        sr_req.isWrite = 1'b0;
        sr_req.addr = a;
        @(posedge clk);
        #1 sr_req.valid = 1'b0;
        @(negedge clk);
        check("oor_no_rsp", 64'(sr_resp.valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic sr_wr(input logic [31:0] a, input logic [63:0] d);
        sr_req.valid = 1'b1;
        sr_req.isWrite = 1'b1;
        sr_req.addr = a;
        sr_req.data = d;
        @(posedge clk);
        #1 sr_req.valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sr_req = '0;
        wpat = {16{32'hDEADBEEF}};
        us.awid = '0; us.awaddr = '0; us.awlen = '0; us.awsize = '0; us.awburst = '0;
        us.awvalid = 0; us.wdata = '0; us.wstrb = '0; us.wlast = 0; us.wvalid = 0;
        us.bready = 0; us.arid = '0; us.araddr = '0; us.arlen = '0; us.arsize = '0;
        us.arburst = '0; us.arvalid = 0; us.rready = 0;
        ds.awready = 0; ds.wready = 0; ds.bid = '0; ds.bresp = '0; ds.bvalid = 0;
        ds.arready = 0; ds.rid = '0; ds.rdata = '0; ds.rresp = '0; ds.rlast = 0;
        ds.rvalid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_resp_valid", 64'(sr_resp.valid), 64'd0);
        check("rst_resp_data", sr_resp.data, 64'd0);
        @(posedge clk);
        #1;
        sr_rd(32'h20, 64'd64);
        sr_rd(32'h28, 64'd64);
        sr_rd(32'h48, 64'd0);
        sr_rd_none(32'h58);
        sr_rd_none(32'h18);

        // Read limit 2: two ARs pass, third stalls until one rlast returns
        sr_wr(32'h20, 64'd2);
        us.arvalid = 1; us.araddr = 64'h1000; ds.arready = 1; us.rready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("ar_gate_m%0d", i), 64'(ds.arvalid), 64'(i < 2));
            check($sformatf("ar_gate_s%0d", i), 64'(us.arready), 64'(i < 2));
            check($sformatf("araddr_%0d", i), ds.araddr, 64'h1000);
            @(posedge clk);
            #1;
        end
        ds.rvalid = 1; ds.rlast = 1; ds.rdata = wpat;
        @(negedge clk);
        check("ar_still_blocked", 64'(ds.arvalid), 64'd0);
        check("r_pass_valid", 64'(us.rvalid), 64'd1);
        check("r_pass_data", us.rdata[63:0], wpat[63:0]);
        @(posedge clk);
        #1 ds.rvalid = 0;
        @(negedge clk);
        check("ar_resume", 64'(ds.arvalid), 64'd1);
        @(posedge clk);
        #1 us.arvalid = 0;
        sr_rd(32'h40, 64'd4);
        sr_rd(32'h48, 64'd2);
        sr_rd(32'h30, 64'd1);

        // Drain to one, then AR handshake and rlast in the same cycle
        ds.rvalid = 1;
        @(posedge clk);
        #1 ds.rvalid = 0;
        us.arvalid = 1; ds.rvalid = 1;
        @(negedge clk);
        check("same_cycle_arready", 64'(us.arready), 64'd1);
        @(posedge clk);
        #1 begin us.arvalid = 0; ds.rvalid = 0; end
        sr_rd(32'h48, 64'd1);
        sr_rd(32'h30, 64'd3);
        sr_wr(32'h30, 64'd0);
        sr_rd(32'h30, 64'd0);

        // Write limit 0 blocks AW; W still passes
        sr_wr(32'h28, 64'd0);
        us.awvalid = 1; ds.awready = 1; us.wvalid = 1; ds.wready = 1;
        us.wdata = wpat; us.bready = 1;
        repeat (4) begin
            @(negedge clk);
            check("aw_blk_s", 64'(us.awready), 64'd0);
            check("aw_blk_m", 64'(ds.awvalid), 64'd0);
            check("w_pass", 64'(ds.wvalid), 64'd1);
            check("w_data", ds.wdata[127:64], wpat[127:64]);
            @(posedge clk);
            #1;
        end
        us.awvalid = 0; us.wvalid = 0;
        sr_wr(32'h28, 64'd200);
        sr_rd(32'h28, 64'd64);
        us.awvalid = 1;
        @(negedge clk);
        check("aw_accept", 64'(us.awready), 64'd1);
        @(posedge clk);
        #1 us.awvalid = 0;
        sr_rd(32'h48, 64'h81);
        ds.bvalid = 1;
        @(posedge clk);
        #1 ds.bvalid = 0;
        sr_rd(32'h38, 64'd1);
        sr_rd(32'h48, 64'd1);

        // B with nothing outstanding: sticky write error, cleared by status write
        ds.bvalid = 1;
        @(posedge clk);
        #1 ds.bvalid = 0;
        sr_rd(32'h48, 64'h8001);
        sr_rd(32'h38, 64'd2);
        sr_wr(32'h48, 64'd0);
        sr_rd(32'h48, 64'd1);
        sr_wr(32'h40, 64'd0);
        sr_rd(32'h40, 64'd0);

`ifdef AXI_THROTTLE_LAT_EN
        // rd_out held at 3 for ten cycles after a clear accumulates 30
        sr_wr(32'h20, 64'd4);
        us.arvalid = 1;
        @(posedge clk);
        @(posedge clk);
        #1 us.arvalid = 0;
        sr_wr(32'h50, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        sr_rd(32'h50, 64'd30);
        sr_rd(32'h48, 64'd3);
`else
        sr_rd(32'h50, 64'd0);
`endif

        // Reset mid-operation returns everything to reset values
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sr_rd(32'h48, 64'd0);
        sr_rd(32'h20, 64'd64);
        sr_rd(32'h28, 64'd64);
        sr_rd(32'h30, 64'd0);

        repeat (2) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
